div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port start_i, input, 1 bit: divide request, held high by EX until ready_o is seen.
REQ-004 The block SHALL have port annul_i, input, 1 bit: cancel in-flight divide (pipeline flush).
REQ-005 The block SHALL have port signed_div_i, input, 1 bit: 1 = signed (DIV), 0 = unsigned (DIVU).
REQ-006 The block SHALL have port opdata1_i, input, 32 bits: dividend.
REQ-007 The block SHALL have port opdata2_i, input, 32 bits: divisor.
REQ-008 The block SHALL have port result_o, output, 64 bits: {remainder -> HI [63:32], quotient -> LO [31:0]}.
REQ-009 The block SHALL have port ready_o, output, 1 bit: result_o valid, HI/LO write may proceed.
REQ-010 The block SHALL have port busy_o, output, 1 bit: EX stall request, high whenever state is neither FREE nor END.
REQ-011 When DIV_ZERO_FLAG_EN is defined, the block SHALL additionally have port div_zero_o, output, 1 bit: divisor-was-zero flag.

Function
REQ-012 The FSM SHALL have states FREE, BYZERO, ON and END, registered with 2-bit encoding.
REQ-013 In FREE, start_i=1 and annul_i=0 SHALL cause the following:
- divisor==0: next state BYZERO;
- otherwise: next state ON, step counter cleared to 0;
- operands latched as absolute values when signed_div_i=1 and the operand is negative.
REQ-014 Operands SHALL be sampled only on the FREE->ON/BYZERO edge; later operand changes SHALL have no effect.
REQ-015 ON SHALL perform one restoring shift-subtract step per cycle using a 65-bit work register and 33-bit subtraction; the counter SHALL increment per step.
REQ-016 After the 32nd step, next state SHALL be END with sign-corrected results:
- quotient negated iff signed and sign(op1) xor sign(op2);
- remainder negated iff signed and op1 negative.
REQ-017 BYZERO SHALL go to END on the next edge with result_o = 0.
REQ-018 In END:
- ready_o=1 and result_o SHALL be held stable;
- when start_i=0, next state SHALL be FREE, ready_o=0 and result_o=0.
REQ-019 Latency: ready_o SHALL rise after the 34th rising edge following first sampling of start_i (nonzero divisor), and after the 2nd edge for a zero divisor.
REQ-020 annul_i=1 in ON or BYZERO SHALL force FREE on the next edge with ready_o=0; annul_i in FREE or END SHALL be ignored except that it blocks a new start in FREE.
REQ-021 Simultaneous start_i and annul_i in FREE SHALL remain in FREE.
REQ-022 Signed -2^31 / -1 SHALL wrap: quotient 0x80000000, remainder 0.
REQ-023 busy_o SHALL be combinational from state; ready_o and result_o SHALL be registered.

Reset
REQ-024 On rst=0, regardless of clk, the block SHALL force the following: state FREE, counter 0, result_o 0, ready_o 0, busy_o 0, div_zero_o 0.
REQ-025 Reset asserted mid-operation SHALL discard the divide; after release the block SHALL wait in FREE for a new start_i.

Configuration
REQ-026 With DIV_ZERO_FLAG_EN defined:
- div_zero_o SHALL be high together with ready_o for divides that went through BYZERO, and 0 otherwise;
- div_zero_o SHALL clear on return to FREE.
REQ-027 With DIV_ZERO_FLAG_EN undefined, the port and its register SHALL be absent; divide-by-zero SHALL still return result_o=0 via BYZERO.

Verification
REQ-028 Unsigned 100 / 7 -> result_o = {HI 0x00000002, LO 0x0000000E}, ready_o high 34 edges after start.
REQ-029 Signed 0xFFFFFFF9 (-7) / 2 -> LO 0xFFFFFFFD, HI 0xFFFFFFFF; busy_o high for cycles 1-33.
REQ-030 Divisor 0 (any dividend) -> ready_o after 2 edges, result_o 0; div_zero_o=1 when DIV_ZERO_FLAG_EN is defined.
REQ-031 annul_i pulsed at step 10 of a divide -> FREE next edge, ready_o never asserts; a following 9/3 divide returns LO 3, HI 0.
REQ-032 Signed 0x80000000 / 0xFFFFFFFF -> LO 0x80000000, HI 0; start_i held 5 extra cycles keeps END and result_o stable.
REQ-033 rst driven low at step 20, then released -> all outputs 0 immediately, state FREE, no ready_o pulse.

Source files
------------

// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider (DIV/DIVU) with annul and a zero-divisor fast path.
// Optional divisor-was-zero flag output enabled by defining DIV_ZERO_FLAG_EN.
module div_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        annul_i,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   output logic [63:0] result_o,
   output logic        ready_o,
   output logic        busy_o
`ifdef DIV_ZERO_FLAG_EN
   ,
   output logic        div_zero_o
`endif
);

   localparam int unsigned DW = 32;
   localparam int unsigned WW = 2 * DW + 1;
   localparam int unsigned CW = 6;
   localparam logic [CW-1:0] STEPS = CW'(DW);

   typedef enum logic [1:0] {
      FREE   = 2'b00,
      BYZERO = 2'b01,
      ON     = 2'b10,
      END    = 2'b11
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [WW-1:0]   work_q, work_d;
   logic [DW-1:0]   divisor_q, divisor_d;
   logic            quot_neg_q, quot_neg_d;
   logic            rem_neg_q, rem_neg_d;
   logic [2*DW-1:0] result_d;
   logic            ready_d;
   logic            dz_d;

   logic [DW-1:0]   op1_abs, op2_abs;
   logic [DW:0]     diff;
   logic [DW-1:0]   quot_raw, rem_raw, quot_fix, rem_fix;

   // Magnitudes are taken only for signed divides; -2^31 maps onto itself, which is the wanted wrap.
   assign op1_abs  = (signed_div_i && opdata1_i[DW-1]) ? (~opdata1_i + DW'(1)) : opdata1_i;
   assign op2_abs  = (signed_div_i && opdata2_i[DW-1]) ? (~opdata2_i + DW'(1)) : opdata2_i;

   // Trial subtraction of the divisor from the upper half of the work register.
   assign diff     = {1'b0, work_q[2*DW-1:DW]} - {1'b0, divisor_q};

   assign quot_raw = work_q[DW-1:0];
   assign rem_raw  = work_q[WW-1:DW+1];
   assign quot_fix = quot_neg_q ? (~quot_raw + DW'(1)) : quot_raw;
   assign rem_fix  = rem_neg_q  ? (~rem_raw  + DW'(1)) : rem_raw;

   assign busy_o   = (state_q == BYZERO) || (state_q == ON);

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      work_d     = work_q;
      divisor_d  = divisor_q;
      quot_neg_d = quot_neg_q;
      rem_neg_d  = rem_neg_q;
      result_d   = result_o;
      ready_d    = ready_o;
      dz_d       = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      dz_d       = div_zero_o;
`endif

      case (state_q)
         FREE: begin
            result_d = '0;
            ready_d  = 1'b0;
            dz_d     = 1'b0;
            if (start_i && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_d = BYZERO;
               end else begin
                  state_d    = ON;
                  cnt_d      = '0;
                  work_d     = {DW'(0), op1_abs, 1'b0};
                  divisor_d  = op2_abs;
                  quot_neg_d = signed_div_i && (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
                  rem_neg_d  = signed_div_i && opdata1_i[DW-1];
               end
            end
         end

         BYZERO: begin
            if (annul_i) begin
               state_d  = FREE;
               result_d = '0;
               ready_d  = 1'b0;
               dz_d     = 1'b0;
            end else begin
               state_d  = END;
               result_d = '0;
               ready_d  = 1'b1;
               dz_d     = 1'b1;
            end
         end

         ON: begin
            if (annul_i) begin
               state_d  = FREE;
               result_d = '0;
               ready_d  = 1'b0;
            end else if (cnt_q != STEPS) begin
               if (diff[DW]) begin
                  work_d = {work_q[2*DW-1:0], 1'b0};
               end else begin
                  work_d = {diff[DW-1:0], work_q[DW-1:0], 1'b1};
               end
               cnt_d = cnt_q + CW'(1);
            end else begin
               state_d  = END;
               result_d = {rem_fix, quot_fix};
               ready_d  = 1'b1;
            end
         end

         END: begin
            // Result is held until EX drops its request.
            if (!start_i) begin
               state_d  = FREE;
               result_d = '0;
               ready_d  = 1'b0;
               dz_d     = 1'b0;
            end
         end

         default: begin
            state_d = FREE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= FREE;
         cnt_q      <= '0;
         work_q     <= '0;
         divisor_q  <= '0;
         quot_neg_q <= 1'b0;
         rem_neg_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         work_q     <= work_d;
         divisor_q  <= divisor_d;
         quot_neg_q <= quot_neg_d;
         rem_neg_q  <= rem_neg_d;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         result_o <= result_d;
         ready_o  <= ready_d;
      end
   end

`ifdef DIV_ZERO_FLAG_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_zero_o <= 1'b0;
      end else begin
         div_zero_o <= dz_d;
      end
   end
`else
   logic unused_dz;
   assign unused_dz = dz_d;
`endif

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: latency, signed/unsigned results,
// zero divisor, annul, start/annul collision, END hold and mid-operation reset.
module tb_div_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        annul_i;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        busy_o;
`ifdef DIV_ZERO_FLAG_EN
   logic        div_zero_o;
`endif

   int checks = 0;
   int errors = 0;

   div_seq dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .busy_o       (busy_o)
`ifdef DIV_ZERO_FLAG_EN
      ,
      .div_zero_o   (div_zero_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_dz(input string tag, input logic exp);
`ifdef DIV_ZERO_FLAG_EN
      check(tag, 64'(div_zero_o), 64'(exp));
`else
      if (exp === 1'bx) check(tag, 64'(1'b0), 64'(1'b1));
`endif
   endtask

   // Issue one divide and wait (bounded) for ready_o; operands are disturbed mid-flight.
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] exp_res, input int exp_edges,
                          input logic exp_dz);
      int  n;
      bit  done;
      n            = 0;
      done         = 0;
      opdata1_i    = a;
      opdata2_i    = b;
      signed_div_i = sgn;
      start_i      = 1'b1;
      while (!done && n < 60) begin
         tick();
         n++;
         if (n == 1) begin
            opdata1_i    = ~a;
            opdata2_i    = b ^ 32'h0000_0005;
            signed_div_i = ~sgn;
         end
         if (ready_o === 1'b1) done = 1;
         else check({tag, "_busy"}, 64'(busy_o), 64'(1'b1));
      end
      check({tag, "_latency"}, 64'(n), 64'(exp_edges));
      check({tag, "_result"}, result_o, exp_res);
      check({tag, "_busy_end"}, 64'(busy_o), 64'(1'b0));
      check_dz({tag, "_dz"}, exp_dz);
   endtask

   task automatic release_start(input string tag);
      start_i = 1'b0;
      tick();
      check({tag, "_rel_ready"}, 64'(ready_o), 64'(1'b0));
      check({tag, "_rel_result"}, result_o, 64'h0);
      check({tag, "_rel_busy"}, 64'(busy_o), 64'(1'b0));
      check_dz({tag, "_rel_dz"}, 1'b0);
   endtask

   initial begin
      int seen;
      logic [63:0] held;

      rst          = 1'b0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;

      #2;
      check("reset_result", result_o, 64'h0);
      check("reset_ready", 64'(ready_o), 64'(1'b0));
      check("reset_busy", 64'(busy_o), 64'(1'b0));
      check_dz("reset_dz", 1'b0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      run_div("u100_7", 32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, 34, 1'b0);
      release_start("u100_7");

      run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 1'b0);
      release_start("s_m7_2");

      run_div("u_big_2", 32'hFFFF_FFF9, 32'd2, 1'b0, {32'h0000_0001, 32'h7FFF_FFFC}, 34, 1'b0);
      release_start("u_big_2");

      run_div("s100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1, {32'h0000_0002, 32'hFFFF_FFF2}, 34, 1'b0);
      release_start("s100_m7");

      run_div("div0_u", 32'd12345, 32'd0, 1'b0, 64'h0, 2, 1'b1);
      release_start("div0_u");

      run_div("div0_s", 32'hFFFF_FFFB, 32'd0, 1'b1, 64'h0, 2, 1'b1);
      release_start("div0_s");

      // Annul after 10 steps.
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd7;
      signed_div_i = 1'b0;
      start_i      = 1'b1;
      for (int i = 0; i < 11; i++) tick();
      check("annul_busy_before", 64'(busy_o), 64'(1'b1));
      annul_i = 1'b1;
      start_i = 1'b0;
      tick();
      check("annul_busy", 64'(busy_o), 64'(1'b0));
      check("annul_ready", 64'(ready_o), 64'(1'b0));
      check("annul_result", result_o, 64'h0);
      annul_i = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ready_o !== 1'b0) seen++;
      end
      check("annul_no_ready", 64'(seen), 64'h0);
      run_div("u9_3", 32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 34, 1'b0);
      release_start("u9_3");

      // Signed overflow case, with extended hold and annul ignored in END.
      run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 34, 1'b0);
      held = result_o;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         opdata1_i = 32'(i * 17 + 3);
         opdata2_i = 32'd1;
         annul_i   = (i == 2);
         tick();
         if (ready_o !== 1'b1 || result_o !== held) seen++;
      end
      annul_i = 1'b0;
      check("hold_stable", 64'(seen), 64'h0);
      check("hold_result", result_o, {32'h0, 32'h8000_0000});
      release_start("s_min_m1");

      // Start and annul together in FREE: no divide begins.
      opdata1_i    = 32'hFFFF_FFFF;
      opdata2_i    = 32'h10;
      signed_div_i = 1'b0;
      start_i      = 1'b1;
      annul_i      = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check("collide_busy", 64'(busy_o), 64'(1'b0));
      check("collide_ready", 64'(ready_o), 64'(1'b0));
      annul_i = 1'b0;
      run_div("u_ff_10", 32'hFFFF_FFFF, 32'h10, 1'b0, {32'h0000_000F, 32'h0FFF_FFFF}, 34, 1'b0);
      release_start("u_ff_10");

      // Reset asserted mid-divide.
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd7;
      signed_div_i = 1'b0;
      start_i      = 1'b1;
      for (int i = 0; i < 21; i++) tick();
      check("prerst_busy", 64'(busy_o), 64'(1'b1));
      rst = 1'b0;
      #1;
      check("midrst_busy", 64'(busy_o), 64'(1'b0));
      check("midrst_ready", 64'(ready_o), 64'(1'b0));
      check("midrst_result", result_o, 64'h0);
      check_dz("midrst_dz", 1'b0);
      start_i = 1'b0;
      #2;
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ready_o !== 1'b0 || busy_o !== 1'b0) seen++;
      end
      check("postrst_idle", 64'(seen), 64'h0);
      run_div("post_rst", 32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 34, 1'b0);
      release_start("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
